// File: rtl/ss_sched_pkg.sv
// ss_sched_pkg: shared types and constants for the DMA stream-port sequencer.
//   state_e    - sequencer states
//   BEAT_*     - 64-bit beat geometry
//   RD_CNT_W   - width of the read-beat counter
//   beats_of() - byte count to beat count, rounded up
package ss_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARB,
    S_RD,
    S_WR,
    S_FIN
  } state_e;

  localparam int BEAT_BYTES = 8;
  localparam int BEAT_SHIFT = 3;
  localparam int RD_CNT_W   = 21;

  // ceil(bytes / 8). The top bit of the sum is dropped, so byte counts above
  // 0xFFFFF8 wrap to a zero-length read side.
  function automatic logic [RD_CNT_W-1:0] beats_of(input logic [23:0] bytes);
    logic [24:0] sum;
    sum = {1'b0, bytes} + 25'(BEAT_BYTES - 1);
    return sum[BEAT_SHIFT +: RD_CNT_W];
  endfunction

endpackage

// File: rtl/ss_rr_arb2.sv
// ss_rr_arb2: 2-way round-robin arbiter.
//   gclk, grst_n - clock, async active-low reset
//   req[1:0]     - requests, bit 0 = read port, bit 1 = write port
//   accept       - the current grant is taken this cycle; pointer advances
//   gnt[1:0]     - one-hot grant (combinational)
// The pointer names the side that wins a tie; it resets to the read side and
// flips to the other side whenever a grant is accepted.
module ss_rr_arb2 (
  input  logic       gclk,
  input  logic       grst_n,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] gnt
);

  logic ptr;  // 0: read wins a tie, 1: write wins a tie

  always_comb begin
    gnt = 2'b00;
    if (req[0] && (!req[1] || !ptr)) gnt[0] = 1'b1;
    else if (req[1])                 gnt[1] = 1'b1;
  end

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n)              ptr <= 1'b0;
    else if (accept && |gnt)  ptr <= gnt[0];
  end

endmodule

// File: rtl/ss_sched.sv
// ss_sched: shares one bus engine between a DMA channel's read stream port
// (ss_*2, fills the source FIFO) and write stream port (ss_*3, drains the
// destination FIFO) in bounded round-robin bursts.
//   wb_clk_i, wb_rst_i        - clock, async active-low reset
//   go, abort, dc             - job start (latches byte count), job clear
//   ss_start2/ss_stop2        - source FIFO room / nearly full
//   ss_start3/ss_stop3/ss_end3- dest FIFO data / nearly empty / head is last
//   bus_ack                   - engine took one 64-bit beat
//   bus_req, bus_we           - burst active, burst direction (1 = write)
//   ss_xfer2, ss_xfer3        - FIFO beat strobes; ss_last2 marks final read
//   busy, done, err, rd_left  - job status, done pulse, timeout, beats left
// Build option: define SS_SCHED_TIMEOUT_EN to abandon a burst after TIMEOUT
// consecutive cycles without bus_ack (sets err); otherwise err stays 0.
module ss_sched
  import ss_sched_pkg::*;
#(
  parameter int BURST_LEN = 8,
  parameter int TIMEOUT   = 1024
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                go,
  input  logic                abort,
  input  logic [23:0]         dc,
  input  logic                ss_start2,
  input  logic                ss_stop2,
  input  logic                ss_start3,
  input  logic                ss_stop3,
  input  logic                ss_end3,
  input  logic                bus_ack,
  output logic                bus_req,
  output logic                bus_we,
  output logic                ss_xfer2,
  output logic                ss_xfer3,
  output logic                ss_last2,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [RD_CNT_W-1:0] rd_left
);

  localparam logic [8:0] BEAT_LAST = 9'(BURST_LEN - 1);

  state_e      state;
  logic        wr_done;
  logic [8:0]  beat_cnt;   // beats moved in the current burst
  logic        in_rd, in_wr;
  logic        rd_ok, wr_ok, fin_ok;
  logic        rd_end, wr_end;
  logic [1:0]  gnt;
  logic        tmo_hit;

  assign in_rd   = (state == S_RD);
  assign in_wr   = (state == S_WR);
  assign bus_req = in_rd | in_wr;
  assign bus_we  = in_wr;

  // Strobes are suppressed during abort so the FIFOs never see a beat the
  // sequencer is about to forget.
  assign ss_xfer2 = in_rd & bus_ack & ~ss_stop2 & ~abort;
  assign ss_xfer3 = in_wr & bus_ack & ~ss_stop3 & ~abort;
  assign ss_last2 = ss_xfer2 & (rd_left == RD_CNT_W'(1));

  assign rd_ok  = (rd_left != '0) & ss_start2 & ~ss_stop2;
  assign wr_ok  = ~wr_done & ss_start3 & ~ss_stop3;
  assign fin_ok = (rd_left == '0) & wr_done;

  assign rd_end = ss_stop2 | (ss_xfer2 & ((beat_cnt == BEAT_LAST) | (rd_left == RD_CNT_W'(1))));
  assign wr_end = ss_stop3 | (ss_xfer3 & ((beat_cnt == BEAT_LAST) | ss_end3));

  ss_rr_arb2 u_arb (
    .gclk   (wb_clk_i),
    .grst_n (wb_rst_i),
    .req    ({wr_ok, rd_ok}),
    .accept ((state == S_ARB) & ~abort & ~fin_ok),
    .gnt    (gnt)
  );

`ifdef SS_SCHED_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0] stall_cnt;  // consecutive burst cycles without bus_ack

  assign tmo_hit = bus_req & ~bus_ack & (stall_cnt == TO_W'(TIMEOUT - 1));

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i)                               stall_cnt <= '0;
    else if (!bus_req || bus_ack || abort || tmo_hit) stall_cnt <= '0;
    else                                         stall_cnt <= stall_cnt + TO_W'(1);
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state    <= S_IDLE;
      rd_left  <= '0;
      wr_done  <= 1'b0;
      beat_cnt <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        state    <= S_IDLE;
        rd_left  <= '0;
        beat_cnt <= '0;
        busy     <= 1'b0;
      end else if (tmo_hit) begin
        state    <= S_IDLE;
        beat_cnt <= '0;
        busy     <= 1'b0;
        err      <= 1'b1;
      end else begin
        case (state)
          S_IDLE: if (go) begin
            rd_left <= beats_of(dc);
            wr_done <= 1'b0;
            busy    <= 1'b1;
            err     <= 1'b0;
            state   <= S_ARB;
          end
          // ARB always lasts at least one cycle, which gives the mandatory
          // bus_req-low gap between bursts.
          S_ARB: begin
            beat_cnt <= '0;
            if (fin_ok) begin
              state <= S_FIN;
              done  <= 1'b1;
            end else if (gnt[0]) state <= S_RD;
            else if (gnt[1])     state <= S_WR;
          end
          S_RD: begin
            if (ss_xfer2) begin
              rd_left  <= rd_left - RD_CNT_W'(1);
              beat_cnt <= beat_cnt + 9'd1;
            end
            if (rd_end) state <= S_ARB;
          end
          S_WR: begin
            if (ss_xfer3) begin
              beat_cnt <= beat_cnt + 9'd1;
              if (ss_end3) wr_done <= 1'b1;
            end
            if (wr_end) state <= S_ARB;
          end
          S_FIN: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ss_sched.sv
// tb_ss_sched: directed scenarios plus randomized traffic for ss_sched,
// checked every cycle against a behavioural model of the sequencing rules.
module tb_ss_sched;

  localparam int BL  = 8;
  localparam int TMO = 16;
  localparam int P_IDLE = 0, P_ARB = 1, P_RD = 2, P_WR = 3, P_FIN = 4;

  logic clk = 1'b0, rst_n = 1'b0;
  logic go = 1'b0, abort = 1'b0;
  logic [23:0] dc = '0;
  logic start2 = 1'b0, stop2 = 1'b0, start3 = 1'b0, stop3 = 1'b0, end3 = 1'b0, ack = 1'b0;
  logic bus_req, bus_we, ss_xfer2, ss_xfer3, ss_last2, busy, done, err;
  logic [20:0] rd_left;

  always #5 clk = ~clk;

  ss_sched #(.BURST_LEN(BL), .TIMEOUT(TMO)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst_n), .go(go), .abort(abort), .dc(dc),
    .ss_start2(start2), .ss_stop2(stop2), .ss_start3(start3), .ss_stop3(stop3),
    .ss_end3(end3), .bus_ack(ack), .bus_req(bus_req), .bus_we(bus_we),
    .ss_xfer2(ss_xfer2), .ss_xfer3(ss_xfer3), .ss_last2(ss_last2),
    .busy(busy), .done(done), .err(err), .rd_left(rd_left)
  );

  int errors = 0, checks = 0;
  // model of the job: phase, beats left, write finished, tie preference
  int m_ph, m_left, m_wdone, m_busy, m_err, m_pref, m_beats, m_stall;
  int n_x2, n_x3, n_l2, n_done, run_len, saved;
  logic prev_req;
  int bursts[$];
  int grants[$];   // 0 = read burst, 1 = write burst
  int e3_beat = -1; // >0: end3 on that write beat, 0: never, -1: driven by caller

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ph = P_IDLE; m_left = 0; m_wdone = 0; m_busy = 0; m_err = 0;
    m_pref = 0; m_beats = 0; m_stall = 0; prev_req = 1'b0;
  endtask

  task automatic clr_stats();
    n_x2 = 0; n_x3 = 0; n_l2 = 0; n_done = 0; run_len = 0;
    bursts.delete(); grants.delete();
  endtask

  // Called at a falling edge with inputs driven; checks this cycle and
  // advances the model across the next rising edge.
  task automatic step();
    logic ex2, ex3, el2, rok, wok, fire;
    if (e3_beat >= 0) end3 = (e3_beat > 0) && (n_x3 == e3_beat - 1);
    #1;
    ex2 = (m_ph == P_RD) && ack && !stop2 && !abort;
    ex3 = (m_ph == P_WR) && ack && !stop3 && !abort;
    el2 = ex2 && (m_left == 1);
    chk("bus_req",  32'(bus_req),  32'(m_ph == P_RD || m_ph == P_WR));
    chk("bus_we",   32'(bus_we),   32'(m_ph == P_WR));
    chk("ss_xfer2", 32'(ss_xfer2), 32'(ex2));
    chk("ss_xfer3", 32'(ss_xfer3), 32'(ex3));
    chk("ss_last2", 32'(ss_last2), 32'(el2));
    chk("busy",     32'(busy),     32'(m_busy));
    chk("done",     32'(done),     32'(m_ph == P_FIN));
    chk("err",      32'(err),      32'(m_err));
    chk("rd_left",  32'(rd_left),  32'(m_left));
    if (ss_xfer2) n_x2++;
    if (ss_xfer3) n_x3++;
    if (ss_last2) n_l2++;
    if (done)     n_done++;
    if (bus_req && !prev_req) begin run_len = 0; grants.push_back(int'(bus_we)); end
    if (ss_xfer2 || ss_xfer3) run_len++;
    if (!bus_req && prev_req) bursts.push_back(run_len);
    prev_req = bus_req;

    fire = 1'b0;
`ifdef SS_SCHED_TIMEOUT_EN
    if ((m_ph == P_RD || m_ph == P_WR) && !abort) begin
      if (ack) m_stall = 0;
      else begin m_stall++; if (m_stall == TMO) begin fire = 1'b1; m_stall = 0; end end
    end else m_stall = 0;
`endif
    if (abort) begin
      m_ph = P_IDLE; m_left = 0; m_busy = 0;
    end else if (fire) begin
      m_ph = P_IDLE; m_err = 1; m_busy = 0;
    end else begin
      case (m_ph)
        P_IDLE: if (go) begin
          m_left = (int'(dc) + 7) / 8; m_wdone = 0; m_busy = 1; m_err = 0; m_ph = P_ARB;
        end
        P_ARB: begin
          rok = (m_left != 0) && start2 && !stop2;
          wok = !m_wdone && start3 && !stop3;
          if (m_left == 0 && m_wdone) m_ph = P_FIN;
          else if (rok && (!wok || m_pref == 0)) begin m_ph = P_RD; m_pref = 1; m_beats = 0; end
          else if (wok) begin m_ph = P_WR; m_pref = 0; m_beats = 0; end
        end
        P_RD: begin
          if (ex2) begin m_left--; m_beats++; end
          if (stop2 || (ex2 && (m_beats == BL || m_left == 0))) m_ph = P_ARB;
        end
        P_WR: begin
          if (ex3) begin m_beats++; if (end3) m_wdone = 1; end
          if (stop3 || (ex3 && (m_beats == BL || end3))) m_ph = P_ARB;
        end
        default: begin m_ph = P_IDLE; m_busy = 0; end
      endcase
    end
    @(negedge clk);
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_until_idle(input int maxc);
    for (int i = 0; i < maxc && m_ph != P_IDLE; i++) step();
    chk("job_end_busy", 32'(busy), 32'd0);
  endtask

  task automatic start_job(input int bytes);
    dc = 24'(bytes); go = 1'b1; step(); go = 1'b0;
  endtask

  initial begin
    model_reset();
    clr_stats();
    #2;
    chk("rst_bus_req", 32'(bus_req), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_rd_left", 32'(rd_left), 0);
    @(negedge clk); rst_n = 1'b1;

    // 40 bytes: 5 read beats, write ends on its 3rd beat
    clr_stats();
    start2 = 1; start3 = 1; ack = 1; e3_beat = 3;
    start_job(40);
    run_until_idle(100);
    chk("d40_xfer2", 32'(n_x2), 5);
    chk("d40_last2", 32'(n_l2), 1);
    chk("d40_xfer3", 32'(n_x3), 3);
    chk("d40_done", 32'(n_done), 1);
    chk("d40_rd_left", 32'(rd_left), 0);

    // 200 bytes with the write port idle: bursts 8,8,8,1
    clr_stats();
    start3 = 0; e3_beat = 0;
    start_job(200);
    run_cycles(50);
    chk("d200_nbursts", 32'(bursts.size()), 4);
    if (bursts.size() == 4) begin
      chk("d200_b0", 32'(bursts[0]), 8);
      chk("d200_b1", 32'(bursts[1]), 8);
      chk("d200_b2", 32'(bursts[2]), 8);
      chk("d200_b3", 32'(bursts[3]), 1);
    end
    start3 = 1; e3_beat = 1;
    run_until_idle(40);
    chk("d200_done", 32'(n_done), 1);

    // both ports eligible: RD,WR,RD,WR then stop3 mid-write, then abort
    clr_stats();
    e3_beat = 0;
    start_job(200);
    for (int i = 0; i < 200; i++) begin
      if (m_ph == P_WR && grants.size() >= 4 && m_beats == 3) break;
      step();
    end
    chk("alt_ngrants", 32'(grants.size()), 4);
    if (grants.size() >= 4) begin
      chk("alt_g0", 32'(grants[0]), 0);
      chk("alt_g1", 32'(grants[1]), 1);
      chk("alt_g2", 32'(grants[2]), 0);
      chk("alt_g3", 32'(grants[3]), 1);
    end
    saved = n_x3;
    stop3 = 1; step(); stop3 = 0;
    chk("stop3_no_xfer3", 32'(n_x3), 32'(saved));
    step();
    if (bursts.size() >= 4) chk("stop3_burst", 32'(bursts[3]), 3);
    for (int i = 0; i < 20 && m_ph != P_RD; i++) step();
    saved = n_x2;
    abort = 1; step(); abort = 0;
    chk("abort_no_xfer2", 32'(n_x2), 32'(saved));
    chk("abort_busy", 32'(busy), 0);
    chk("abort_rd_left", 32'(rd_left), 0);
    run_cycles(3);
    chk("abort_no_done", 32'(n_done), 0);

    // dc = 0: only the write side; then dc = 1: a single read beat
    clr_stats();
    e3_beat = 1;
    start_job(0);
    run_until_idle(50);
    chk("d0_xfer2", 32'(n_x2), 0);
    chk("d0_xfer3", 32'(n_x3), 1);
    chk("d0_done", 32'(n_done), 1);
    clr_stats();
    start_job(1);
    run_until_idle(50);
    chk("d1_xfer2", 32'(n_x2), 1);
    chk("d1_last2", 32'(n_l2), 1);
    chk("d1_done", 32'(n_done), 1);

`ifdef SS_SCHED_TIMEOUT_EN
    clr_stats();
    start3 = 0; ack = 0; e3_beat = 0;
    start_job(80);
    run_cycles(TMO + 6);
    chk("tmo_err", 32'(err), 1);
    chk("tmo_busy", 32'(busy), 0);
    chk("tmo_no_done", 32'(n_done), 0);
`endif

    // randomized traffic with one asynchronous reset in the middle
    e3_beat = -1;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        rst_n = 1'b0;
        #1;
        chk("mid_rst_bus_req", 32'(bus_req), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_rd_left", 32'(rd_left), 0);
        chk("mid_rst_xfer2", 32'(ss_xfer2), 0);
        model_reset();
        @(negedge clk); rst_n = 1'b1;
      end
      if (m_ph == P_IDLE && $urandom_range(0, 3) == 0) begin
        go = 1'b1;
        dc = ($urandom_range(0, 7) == 0) ? 24'd0 : 24'($urandom_range(1, 400));
      end else begin
        go = ($urandom_range(0, 50) == 0);
        dc = 24'($urandom_range(0, 400));
      end
      abort  = ($urandom_range(0, 300) == 0);
      start2 = ($urandom_range(0, 7) != 0);
      stop2  = ($urandom_range(0, 7) == 0);
      start3 = ($urandom_range(0, 7) != 0);
      stop3  = ($urandom_range(0, 7) == 0);
      end3   = ($urandom_range(0, 5) == 0);
      ack    = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
